// File: rtl/multdiv_ctrl.sv
// Sequencer for the shared multi-cycle multiply/divide datapath: accepts start
// pulses, issues load/step strobes, counts iterations and signals completion.
module multdiv_ctrl #(
  parameter int CNT_W      = 5,
  parameter int MULT_STEPS = 16,
  parameter int DIV_STEPS  = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             div_zero,
  output logic             load,
  output logic             step,
  output logic             is_div,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             data_resultRDY,
  output logic             data_exception
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_STEPS - 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_STEPS - 1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_count, w_count_nxt;
  logic             r_is_div, w_is_div_nxt;
  logic             r_exc, w_exc_nxt;
  logic             w_start;
  logic             w_start_div;
  logic [CNT_W-1:0] w_last_idx;

  // Multiply wins when both starts arrive together.
  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_start_div = ctrl_DIV & ~ctrl_MULT;
  assign w_last_idx  = r_is_div ? DIV_LAST : MULT_LAST;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latches).
    w_state_nxt  = r_state;
    w_count_nxt  = r_count;
    w_is_div_nxt = r_is_div;
    w_exc_nxt    = r_exc;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_count_nxt = '0;
        if (w_start) begin
          w_state_nxt  = S_LOAD;
          w_is_div_nxt = w_start_div;
          w_exc_nxt    = w_start_div & div_zero;
        end else begin
          w_state_nxt  = S_IDLE;
        end
      end
      // A divide by zero skips the iterations entirely.
      S_LOAD: begin
        w_count_nxt = '0;
        w_state_nxt = r_exc ? S_DONE : S_RUN;
      end
      // count freezes on the last index so DONE reports N-1.
      S_RUN: begin
        if (r_count == w_last_idx) begin
          w_state_nxt = S_DONE;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (clr) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_is_div <= 1'b0;
      r_exc    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_is_div <= w_is_div_nxt;
      r_exc    <= w_exc_nxt;
    end
  end

  // Outputs decode registered state only; no input reaches them combinationally.
  assign load           = (r_state == S_LOAD);
  assign step           = (r_state == S_RUN);
  assign busy           = (r_state == S_LOAD) || (r_state == S_RUN);
  assign data_resultRDY = (r_state == S_DONE);
  assign data_exception = (r_state == S_DONE) & r_exc;
  assign is_div         = r_is_div;
  assign count          = r_count;

endmodule
